data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Parametrised, byte-addressable RV32I data memory with load/store sizing, sign extension and a valid/ready request handshake. It replaces the fixed word-only data memory between the execute/memory stage and writeback. It handles LB/LH/LW/LBU/LHU/SB/SH/SW directly from funct3, and splits word-boundary-crossing accesses into two internal cycles. It reports out-of-range and illegal requests, and zero-fills its array after reset.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words in the array (≥2)
- ADDR_WIDTH, 32, byte address width
- BASE_ADDR, 0, byte address of word 0 (word-aligned)

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- we  in  1  1 = store, 0 = load
- funct3  in  3  access type: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only)
- addr  in  ADDR_WIDTH  byte address
- data  in  32  store data; low 8/16/32 bits are used
- q  out  32  load result, sign- or zero-extended
- rsp_valid  out  1  one-cycle response pulse, for loads and stores
- err  out  1  valid only with rsp_valid; request rejected

## Operation
- The block has three states.
  - CLEAR: entered whenever rst is sampled high. The counter is set to 0. In each cycle with rst low, mem[counter] is written to 0 and counter increments. After mem[DEPTH_WORDS-1] is written, the state goes to IDLE.
  - IDLE: req_ready=1.
  - SPLIT: req_ready=0; the block performs the second half of a crossing access.
- A request is accepted when req_valid and req_ready are both 1 at a rising edge.
- Offset: off = addr - BASE_ADDR.
  - Word index: off[.. :2].
  - Byte lane: off[1:0].
  - Size: 1, 2 or 4 bytes.
- Error cases. err=1, no write, q=0.
  - funct3 is 011, 110 or 111.
  - A store uses funct3 100 or 101.
  - off+size-1 ≥ 4·DEPTH_WORDS.
  - addr < BASE_ADDR.
- Crossing condition: lane+size > 4. This covers H at lane 3 and W at lanes 1, 2 and 3. A crossing access uses words idx and idx+1.
  - Store: the low bytes go to word idx at the accept edge. The remaining bytes go to word idx+1 on the SPLIT edge. Only the addressed bytes change.
  - Load: bytes are gathered from both words and assembled little-endian before extension.
- Non-crossing store: byte-lane write enables. Unaddressed bytes of the word are unchanged.
- Load extension:
  - B/H sign-extend from bit 7/15.
  - BU/HU zero-extend.
  - W passes through unchanged.
- Store response: rsp_valid=1, err=0, q=0.
- q holds its value between responses.

## Timing
- Reset values: req_ready=0, rsp_valid=0, err=0, q=0, state=CLEAR, counter=0.
- req_ready rises exactly DEPTH_WORDS cycles after the first rising edge with rst low.
- Non-crossing and error requests:
  - rsp_valid pulses on the cycle after acceptance (1-cycle latency).
  - req_ready stays 1, so back-to-back requests give back-to-back responses.
- Crossing request:
  - The accept edge enters SPLIT; req_ready=0 for one cycle.
  - rsp_valid pulses 2 cycles after acceptance.
  - The next request can be accepted on the edge where SPLIT returns to IDLE.
- Read ordering: a load sees all stores accepted on earlier edges, including the second half of a preceding split store. The array is single-port, so there is no same-edge read/write ambiguity.
- Reset mid-operation:
  - rst high in SPLIT abandons the access. No response is issued. A half-written store is then zeroed by CLEAR.
  - rst high in CLEAR restarts the counter at 0.
- Requests are ignored while req_ready=0. No state changes and no response.

## Test plan
- Reset and clear: write SW 45 at addr 77&~3=76 before reset, then pulse rst for 1 cycle. req_ready must stay 0 for exactly DEPTH_WORDS cycles. LW at 76 must then return 0.
- Word round trip: SW data=45 at 76, then LW at 76. rsp_valid=1 one cycle after each request, q=45. With req_valid low, the array is unchanged and LW still returns 45.
- Byte and half lanes with extension: SW 0x11223344 at 0x10, then SB 0x80 at 0x11.
  - LW gives 0x11228044.
  - LB at 0x11 gives 0xFFFFFF80; LBU gives 0x00000080.
  - LH at 0x12 gives 0x00001122.
  - SH 0xBEEF at 0x12, then LHU at 0x12 gives 0x0000BEEF.
- Crossing access: SW 0xAABBCCDD at 0x13.
  - req_ready=0 for 1 cycle; rsp_valid 2 cycles after accept.
  - LW at 0x10 gives 0xDD??????, with upper byte from the new store and low bytes preserved.
  - LW at 0x13 gives 0xAABBCCDD.
  - LH at 0x17 crossing gives the sign-extended value of bytes 0x17/0x18.
- Errors:
  - funct3=011 gives err=1, q=0.
  - SB with funct3=100 gives err=1 and no write.
  - LW at BASE_ADDR+4·DEPTH_WORDS-2 gives err=1.
  - Each error response arrives 1 cycle after request.
- Reset during SPLIT: start crossing SW at 0x13, assert rst on the next cycle. No rsp_valid is issued. After CLEAR, LW at 0x10 and 0x14 both give 0.

Source files
------------

// File: rtl/data_memory_lsu.sv
// rtl/data_memory_lsu.sv - byte-addressable RV32I data memory with sized loads/stores
// and two-cycle handling of word-boundary-crossing accesses.
module data_memory_lsu #(
    parameter int                    DEPTH_WORDS = 256,
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_we,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_data,
    output logic [31:0]           o_q,
    output logic                  o_rsp_valid,
    output logic                  o_err
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef logic [ADDR_WIDTH:0] ext_t;
    localparam ext_t             MEM_BYTES = ext_t'(4 * DEPTH_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH_WORDS - 1);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_SPLIT = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_clr_cnt;
    logic [31:0]      r_mem [DEPTH_WORDS];

    logic             r_rsp_valid;
    logic             r_err;
    logic [31:0]      r_q;

    logic             r_sp_we;
    logic [2:0]       r_sp_f3;
    logic [1:0]       r_sp_lane;
    logic [31:0]      r_lo_word;
    logic [IDX_W-1:0] r_hi_idx;
    logic [3:0]       r_hi_be;
    logic [31:0]      r_hi_data;

    ext_t             w_off_full;
    logic [ADDR_WIDTH-1:0] w_off;
    ext_t             w_last;
    logic [2:0]       w_size;
    logic [3:0]       w_mask4;
    logic             w_bad_f3;
    logic             w_err;
    logic [1:0]       w_lane;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_idx_hi;
    logic             w_cross;
    logic [7:0]       w_be64;
    logic [63:0]      w_sd64;
    logic [31:0]      w_rd_lo;
    logic [31:0]      w_rd_hi;
    logic             w_accept;

    function automatic logic [31:0] load_extend(input logic [63:0] dw,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] b;
        b = dw[lane*8 +: 32];
        case (f3)
            3'b000:  return {{24{b[7]}}, b[7:0]};
            3'b001:  return {{16{b[15]}}, b[15:0]};
            3'b100:  return {24'h0, b[7:0]};
            3'b101:  return {16'h0, b[15:0]};
            default: return b;
        endcase
    endfunction

    always_comb begin
        w_size   = 3'd1;
        w_mask4  = 4'b0001;
        w_bad_f3 = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: begin w_size = 3'd1; w_mask4 = 4'b0001; end
            3'b001, 3'b101: begin w_size = 3'd2; w_mask4 = 4'b0011; end
            3'b010:         begin w_size = 3'd4; w_mask4 = 4'b1111; end
            default:        w_bad_f3 = 1'b1;
        endcase
        if (i_we && i_funct3[2]) begin
            w_bad_f3 = 1'b1;
        end
    end

    // Borrow out of the extended subtraction flags addresses below the base.
    assign w_off_full = {1'b0, i_addr} - {1'b0, BASE_ADDR};
    assign w_off      = w_off_full[ADDR_WIDTH-1:0];
    assign w_last     = {1'b0, w_off} + ext_t'(w_size) - ext_t'(1);
    assign w_err      = w_bad_f3 | w_off_full[ADDR_WIDTH] | (w_last >= MEM_BYTES);

    assign w_lane   = w_off[1:0];
    assign w_idx    = w_off[IDX_W+1:2];
    assign w_idx_hi = w_idx + 1'b1;
    assign w_cross  = ({1'b0, w_lane} + w_size) > 3'd4;

    // Lanes/data spread over two words: low half is word idx, high half is idx+1.
    assign w_be64 = {4'b0000, w_mask4} << w_lane;
    assign w_sd64 = {32'h0, i_data} << {w_lane, 3'b000};

    assign w_rd_lo  = r_mem[w_idx];
    assign w_rd_hi  = r_mem[r_hi_idx];
    assign w_accept = i_req_valid && (r_state == S_IDLE);

    assign o_req_ready = (r_state == S_IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_err       = r_err;
    assign o_q         = r_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_CLEAR: if (r_clr_cnt == LAST_IDX) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_accept && !w_err && w_cross) w_state_nxt = S_SPLIT;
            S_SPLIT: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clr_cnt   <= '0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_q         <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                S_CLEAR: r_clr_cnt <= r_clr_cnt + 1'b1;
                S_IDLE: begin
                    if (i_req_valid) begin
                        if (w_err) begin
                            r_rsp_valid <= 1'b1;
                            r_err       <= 1'b1;
                            r_q         <= '0;
                        end else if (w_cross) begin
                            r_sp_we   <= i_we;
                            r_sp_f3   <= i_funct3;
                            r_sp_lane <= w_lane;
                            r_lo_word <= w_rd_lo;
                            r_hi_idx  <= w_idx_hi;
                            r_hi_be   <= w_be64[7:4];
                            r_hi_data <= w_sd64[63:32];
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_q <= i_we ? 32'h0 : load_extend({32'h0, w_rd_lo}, w_lane, i_funct3);
                        end
                    end
                end
                S_SPLIT: begin
                    r_rsp_valid <= 1'b1;
                    r_q <= r_sp_we ? 32'h0 : load_extend({w_rd_hi, r_lo_word}, r_sp_lane, r_sp_f3);
                end
                default: ;
            endcase
        end
    end

    // Single write port: clear sweep, accept-edge store, or second half of a split store.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (r_state == S_CLEAR) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_accept && i_we && !w_err) begin
                for (int b = 0; b < 4; b++) begin
                    if (w_be64[b]) r_mem[w_idx][8*b +: 8] <= w_sd64[8*b +: 8];
                end
            end else if (r_state == S_SPLIT && r_sp_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (r_hi_be[b]) r_mem[r_hi_idx][8*b +: 8] <= r_hi_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb/tb_data_memory_lsu.sv - self-checking bench for data_memory_lsu against a byte-array model
module tb_data_memory_lsu;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst, req_valid, req_ready, we, rsp_valid, err;
    logic [2:0]  funct3;
    logic [31:0] addr, data, q;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] mref [4*DEPTH];

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] d;
    } op_t;

    always #5 clk = ~clk;

    data_memory_lsu #(.DEPTH_WORDS(DEPTH), .ADDR_WIDTH(32), .BASE_ADDR(32'h0)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_we(we), .i_funct3(funct3), .i_addr(addr), .i_data(data),
        .o_q(q), .o_rsp_valid(rsp_valid), .o_err(err)
    );

    function automatic op_t mk(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        op_t o;
        o.we = w; o.f3 = f; o.a = a; o.d = d;
        return o;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4*DEPTH; i++) mref[i] = 8'h00;
    endtask

    task automatic model_op(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                            output logic e, output logic [31:0] r, output int lat);
        int size;
        logic [31:0] v;
        case (f)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        e = (size == 0) || (w && f[2]) || (longint'(a) + size - 1 >= 4*DEPTH);
        r = 32'h0;
        lat = 1;
        if (!e) begin
            if (int'(a % 4) + size > 4) lat = 2;
            if (w) begin
                for (int i = 0; i < size; i++) mref[int'(a) + i] = d[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mref[int'(a) + i];
                if (!f[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                r = v;
            end
        end
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                         output int lat, output logic rdy_after, output logic [31:0] g, output logic ge);
        int k;
        k = 0;
        while (req_ready !== 1'b1 && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        req_valid = 1'b1; we = w; funct3 = f; addr = a; data = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        we = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; data = $urandom;
        rdy_after = req_ready;
        lat = -1; g = 'x; ge = 'x;
        for (int c = 1; c <= 4; c++) begin
            if (rsp_valid === 1'b1) begin
                lat = c; g = q; ge = err;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        int cnt, lat, el;
        logic rdy, ge, ee;
        logic [31:0] g, eq;
        op_t ops[$];
        rst = 1'b1; req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || err !== 1'b0 || q !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b rsp=%b err=%b q=%h, want 0 0 0 0", req_ready, rsp_valid, err, q);
        end
        rst = 1'b0; cnt = 0;
        while (req_ready !== 1'b1 && cnt < 4*DEPTH) begin @(posedge clk); #1; cnt++; end
        n_vec++;
        if (cnt !== DEPTH) begin
            n_bad++;
            $display("FAIL clear_cycles: got %0d, want %0d", cnt, DEPTH);
        end
        model_clear();
        ops.push_back(mk(1'b1, 3'b010, 32'd76, 32'd45));
        ops.push_back(mk(1'b0, 3'b010, 32'd76, 32'd0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL pre_reset[%0d]: got lat=%0d err=%b q=%h, want lat=%0d err=%b q=%h", i, lat, ge, g, el, ee, eq);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || q !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_pulse_outputs: got rdy=%b rsp=%b q=%h, want 0 0 0", req_ready, rsp_valid, q);
        end
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 4*DEPTH) begin @(posedge clk); #1; cnt++; end
        n_vec++;
        if (cnt !== DEPTH) begin
            n_bad++;
            $display("FAIL reclear_cycles: got %0d, want %0d", cnt, DEPTH);
        end
        model_clear();
        issue(1'b0, 3'b010, 32'd76, 32'd0, lat, rdy, g, ge);
        n_vec++;
        if (lat !== 1 || ge !== 1'b0 || g !== 32'h0) begin
            n_bad++;
            $display("FAIL cleared_load: got lat=%0d err=%b q=%h, want lat=1 err=0 q=0", lat, ge, g);
        end
    endtask

    task automatic test_word();
        int lat, el;
        logic rdy, ge, ee;
        logic [31:0] g, eq;
        op_t ops[$];
        ops.push_back(mk(1'b1, 3'b010, 32'd76, 32'd45));
        ops.push_back(mk(1'b0, 3'b010, 32'd76, 32'd0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL word[%0d]: got lat=%0d err=%b q=%h, want lat=%0d err=%b q=%h", i, lat, ge, g, el, ee, eq);
            end
        end
        for (int c = 0; c < 3; c++) begin
            we = 1'b1; funct3 = 3'b010; addr = 32'd76; data = $urandom;
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL idle_no_rsp[%0d]: got rsp=%b, want 0", c, rsp_valid);
            end
        end
        issue(1'b0, 3'b010, 32'd76, 32'd0, lat, rdy, g, ge);
        model_op(1'b0, 3'b010, 32'd76, 32'd0, ee, eq, el);
        n_vec++;
        if (lat !== el || ge !== ee || g !== eq) begin
            n_bad++;
            $display("FAIL word_after_idle: got lat=%0d q=%h, want lat=%0d q=%h", lat, g, el, eq);
        end
    endtask

    task automatic test_lanes();
        int lat, el;
        logic rdy, ge, ee;
        logic [31:0] g, eq;
        op_t ops[$];
        ops.push_back(mk(1'b1, 3'b010, 32'h10, 32'h11223344));
        ops.push_back(mk(1'b1, 3'b000, 32'h11, 32'h00000080));
        ops.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        ops.push_back(mk(1'b0, 3'b000, 32'h11, 32'h0));
        ops.push_back(mk(1'b0, 3'b100, 32'h11, 32'h0));
        ops.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0));
        ops.push_back(mk(1'b1, 3'b001, 32'h12, 32'h0000BEEF));
        ops.push_back(mk(1'b0, 3'b101, 32'h12, 32'h0));
        ops.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL lanes[%0d]: got lat=%0d err=%b q=%h, want lat=%0d err=%b q=%h", i, lat, ge, g, el, ee, eq);
            end
        end
    endtask

    task automatic test_cross();
        int lat, el;
        logic rdy, ge, ee, erdy;
        logic [31:0] g, eq;
        op_t ops[$];
        model_op(1'b1, 3'b010, 32'h13, 32'hAABBCCDD, ee, eq, el);
        req_valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h13; data = 32'hAABBCCDD;
        @(posedge clk); #1;
        addr = 32'h20; data = 32'hDEADBEEF;
        n_vec++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cross_split_cycle: got rdy=%b rsp=%b, want 0 0", req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_vec++;
        if (rsp_valid !== 1'b1 || err !== 1'b0 || q !== 32'h0 || req_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL cross_rsp: got rsp=%b err=%b q=%h rdy=%b, want 1 0 0 1", rsp_valid, err, q, req_ready);
        end
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL cross_single_rsp: got rsp=%b, want 0", rsp_valid);
        end
        ops.push_back(mk(1'b1, 3'b000, 32'h17, 32'h34));
        ops.push_back(mk(1'b1, 3'b000, 32'h18, 32'hC2));
        ops.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h13, 32'h0));
        ops.push_back(mk(1'b0, 3'b001, 32'h17, 32'h0));
        ops.push_back(mk(1'b0, 3'b101, 32'h17, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0));
        ops.push_back(mk(1'b1, 3'b001, 32'h1B, 32'h00009876));
        ops.push_back(mk(1'b0, 3'b010, 32'h18, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h1C, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h1A, 32'h0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            erdy = (el == 2) ? 1'b0 : 1'b1;
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== erdy) begin
                n_bad++;
                $display("FAIL cross[%0d]: got lat=%0d err=%b q=%h rdy=%b, want lat=%0d err=%b q=%h rdy=%b",
                         i, lat, ge, g, rdy, el, ee, eq, erdy);
            end
        end
    endtask

    task automatic test_errors();
        int lat, el;
        logic rdy, ge, ee;
        logic [31:0] g, eq;
        op_t ops[$];
        ops.push_back(mk(1'b0, 3'b011, 32'h0, 32'h0));
        ops.push_back(mk(1'b0, 3'b110, 32'h4, 32'h0));
        ops.push_back(mk(1'b0, 3'b111, 32'h8, 32'h0));
        ops.push_back(mk(1'b1, 3'b100, 32'h10, 32'h5A));
        ops.push_back(mk(1'b1, 3'b101, 32'h10, 32'h5A5A));
        ops.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'(4*DEPTH - 2), 32'h0));
        ops.push_back(mk(1'b0, 3'b001, 32'(4*DEPTH - 1), 32'h0));
        ops.push_back(mk(1'b1, 3'b000, 32'(4*DEPTH - 1), 32'hF1));
        ops.push_back(mk(1'b0, 3'b000, 32'(4*DEPTH - 1), 32'h0));
        ops.push_back(mk(1'b1, 3'b010, 32'(4*DEPTH - 4), 32'h12345678));
        ops.push_back(mk(1'b1, 3'b010, 32'(4*DEPTH - 3), 32'hFFFFFFFF));
        ops.push_back(mk(1'b0, 3'b010, 32'(4*DEPTH - 4), 32'h0));
        ops.push_back(mk(1'b0, 3'b000, 32'(4*DEPTH), 32'h0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== 1'b1) begin
                n_bad++;
                $display("FAIL errors[%0d]: got lat=%0d err=%b q=%h, want lat=%0d err=%b q=%h", i, lat, ge, g, el, ee, eq);
            end
        end
    endtask

    task automatic test_back_to_back();
        int el;
        logic ee;
        logic [31:0] eq;
        op_t ops[$];
        ops.push_back(mk(1'b1, 3'b010, 32'h20, 32'hCAFEF00D));
        ops.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0));
        ops.push_back(mk(1'b1, 3'b000, 32'h21, 32'h7F));
        ops.push_back(mk(1'b0, 3'b001, 32'h20, 32'h0));
        ops.push_back(mk(1'b0, 3'b011, 32'h20, 32'h0));
        ops.push_back(mk(1'b0, 3'b100, 32'h23, 32'h0));
        ops.push_back(mk(1'b1, 3'b001, 32'h22, 32'h8000));
        ops.push_back(mk(1'b0, 3'b001, 32'h22, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h20, 32'h0));
        for (int i = 0; i < ops.size(); i++) begin
            req_valid = 1'b1; we = ops[i].we; funct3 = ops[i].f3; addr = ops[i].a; data = ops[i].d;
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            @(posedge clk); #1;
            n_vec++;
            if (rsp_valid !== 1'b1 || err !== ee || q !== eq || req_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got rsp=%b err=%b q=%h rdy=%b, want 1 %b %h 1", i, rsp_valid, err, q, req_ready, ee, eq);
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_tail: got rsp=%b, want 0", rsp_valid);
        end
    endtask

    task automatic test_random();
        int lat, el;
        logic rdy, ge, ee, erdy, w;
        logic [2:0] f;
        logic [31:0] g, eq, a, d;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(4*DEPTH - 24, 4*DEPTH + 2))
                                            : 32'($urandom_range(0, 63));
            d = $urandom;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            issue(w, f, a, d, lat, rdy, g, ge);
            model_op(w, f, a, d, ee, eq, el);
            erdy = (el == 2) ? 1'b0 : 1'b1;
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq || rdy !== erdy) begin
                n_bad++;
                $display("FAIL rand[%0d] we=%b f3=%b a=%h: got lat=%0d err=%b q=%h rdy=%b, want lat=%0d err=%b q=%h rdy=%b",
                         n, w, f, a, lat, ge, g, rdy, el, ee, eq, erdy);
            end
        end
    endtask

    task automatic test_reset_split();
        int cnt, lat, el;
        logic saw, rdy, ge, ee;
        logic [31:0] g, eq;
        op_t ops[$];
        req_valid = 1'b1; we = 1'b1; funct3 = 3'b010; addr = 32'h13; data = 32'h5EC0DE77;
        @(posedge clk); #1;
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        saw = (rsp_valid === 1'b1);
        cnt = 0;
        while (req_ready !== 1'b1 && cnt < 4*DEPTH) begin
            @(posedge clk); #1;
            cnt++;
            if (rsp_valid === 1'b1) saw = 1'b1;
        end
        n_vec++;
        if (saw !== 1'b0) begin
            n_bad++;
            $display("FAIL split_reset_no_rsp: got a response, want none");
        end
        n_vec++;
        if (cnt !== DEPTH) begin
            n_bad++;
            $display("FAIL split_reset_clear: got %0d cycles, want %0d", cnt, DEPTH);
        end
        model_clear();
        ops.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h14, 32'h0));
        ops.push_back(mk(1'b0, 3'b010, 32'h13, 32'h0));
        for (int i = 0; i < ops.size(); i++) begin
            issue(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, lat, rdy, g, ge);
            model_op(ops[i].we, ops[i].f3, ops[i].a, ops[i].d, ee, eq, el);
            n_vec++;
            if (lat !== el || ge !== ee || g !== eq) begin
                n_bad++;
                $display("FAIL split_reset_load[%0d]: got lat=%0d err=%b q=%h, want lat=%0d err=%b q=%h", i, lat, ge, g, el, ee, eq);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; we = 1'b0; funct3 = 3'b000; addr = 32'h0; data = 32'h0;
        test_reset();
        test_word();
        test_lanes();
        test_cross();
        test_errors();
        test_back_to_back();
        test_random();
        test_reset_split();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
